cache_mem_arbiter: RTL and testbench

Sequential arbiter sharing the single RAM port between the instruction-fetch requester and the data-memory requester of the pipelined CPU. It sits between the cache-side request interfaces and the RAM, and sequences one transfer at a time with a three-state grant FSM. Data requests have priority, and a starvation counter bounds how long instruction fetch can be held off. Wait signals back to each requester implement the stall handshake the pipeline relies on.

---
 rtl/cpu_types_pkg.sv | 24 ++
 rtl/cache_mem_arbiter_if.sv | 32 +++
 rtl/arb_starve_ctr.sv | 35 +++
 rtl/cache_mem_arbiter.sv | 123 ++++++++++++
 tb/tb_cache_mem_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared RAM status and arbiter state types for the CPU memory path
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

  localparam int STARVE_W = 4;

  // Only ACCESS finishes a transfer; BUSY, FREE and ERROR all hold the grant.
  function automatic logic ram_done(input logic [1:0] rs);
    return rs == 2'(ACCESS);
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// rtl/cache_mem_arbiter_if.sv - requester and RAM side signals of the cache/memory arbiter
interface cache_mem_arbiter_if #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic [WORD_W-1:0] iload;
  logic              iwait;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic [WORD_W-1:0] dload;
  logic              dwait;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  logic [1:0]        ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/arb_starve_ctr.sv
// rtl/arb_starve_ctr.sv - saturating count of data grants won while fetch waits
module arb_starve_ctr
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic CLK,
  input  logic nRST,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [STARVE_W-1:0] cnt_q, cnt_d;

  assign sat = (cnt_q == STARVE_W'(STARVE_MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - single RAM port arbiter, data priority with fetch starvation bound
// Optional ARB_PERF_EN adds grant and stall performance counters.
module cache_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                 CLK,
  input  logic                 nRST,
  cache_mem_arbiter_if.slave   bus
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]          perf_igrants,
  output logic [31:0]          perf_dgrants,
  output logic [31:0]          perf_stalls
`endif
);

  arb_state_t state_q, state_d;
  logic       dreq;
  logic       ram_ok;
  logic       i_done;
  logic       d_done;
  logic       starve_sat;

  assign dreq   = bus.dREN | bus.dWEN;
  assign ram_ok = ram_done(bus.ramstate);
  assign i_done = (state_q == IGNT) && bus.iREN && ram_ok;
  assign d_done = (state_q == DGNT) && dreq && ram_ok;

  assign bus.iload = bus.ramload;
  assign bus.dload = bus.ramload;

  arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .CLK (CLK),
    .nRST(nRST),
    .inc (d_done && bus.iREN),
    .clr (i_done || ((state_q == IDLE) && !bus.iREN)),
    .sat (starve_sat)
  );

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Enables follow the live request so a dropped request aborts within the same cycle.
  always_comb begin
    state_d      = state_q;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = ADDR_W'(0);
    bus.ramstore = WORD_W'(0);
    bus.iwait    = bus.iREN;
    bus.dwait    = dreq;
    case (state_q)
      IDLE: begin
        if (dreq && !(bus.iREN && starve_sat)) begin
          state_d = DGNT;
        end else if (bus.iREN) begin
          state_d = IGNT;
        end
      end
      IGNT: begin
        bus.ramaddr = bus.iaddr;
        bus.ramREN  = bus.iREN;
        bus.iwait   = bus.iREN && !ram_ok;
        if (!bus.iREN || ram_ok) begin
          state_d = IDLE;
        end
      end
      DGNT: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN && !bus.dWEN;
        bus.dwait    = dreq && !ram_ok;
        if (!dreq || ram_ok) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef ARB_PERF_EN
  logic [31:0] perf_igrants_q, perf_dgrants_q, perf_stalls_q;
  logic        granted;

  assign granted      = (state_q == IGNT) || (state_q == DGNT);
  assign perf_igrants = perf_igrants_q;
  assign perf_dgrants = perf_dgrants_q;
  assign perf_stalls  = perf_stalls_q;

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      perf_igrants_q <= '0;
      perf_dgrants_q <= '0;
      perf_stalls_q  <= '0;
    end else begin
      if (i_done) begin
        perf_igrants_q <= perf_igrants_q + 32'd1;
      end
      if (d_done) begin
        perf_dgrants_q <= perf_dgrants_q + 32'd1;
      end
      if (granted && !ram_ok) begin
        perf_stalls_q <= perf_stalls_q + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed and randomized checks of cache_mem_arbiter against a transfer-level model
module tb_cache_mem_arbiter;
  localparam int WW = 32;
  localparam int AW = 32;
  localparam int SM = 4;
  localparam logic [1:0] RS_FREE = 2'd0;
  localparam logic [1:0] RS_BUSY = 2'd1;
  localparam logic [1:0] RS_ACC  = 2'd2;
  localparam logic [1:0] RS_ERR  = 2'd3;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  cache_mem_arbiter_if #(.WORD_W(WW), .ADDR_W(AW)) bus ();
`ifdef ARB_PERF_EN
  logic [31:0] perf_igrants, perf_dgrants, perf_stalls;
`endif

  cache_mem_arbiter #(.WORD_W(WW), .ADDR_W(AW), .STARVE_MAX(SM)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
`ifdef ARB_PERF_EN
    ,
    .perf_igrants(perf_igrants),
    .perf_dgrants(perf_dgrants),
    .perf_stalls (perf_stalls)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: who owns the RAM (0 none, 1 fetch, 2 data) and how many data wins fetch has sat through.
  int owner, dstreak, n_ig, n_dg, n_st;
  bit last_done_i, last_done_d;
  bit watch, seen_i;
  int dcnt;

  task automatic reset_model();
    owner = 0; dstreak = 0; n_ig = 0; n_dg = 0; n_st = 0;
    last_done_i = 0; last_done_d = 0;
  endtask

  task automatic compare_outputs();
    logic dq, acc, e_ren, e_wen, e_iw, e_dw;
    logic [31:0] e_addr, e_store;
    dq = bus.dREN | bus.dWEN;
    acc = (bus.ramstate == RS_ACC);
    e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0; e_iw = bus.iREN; e_dw = dq;
    if (owner == 1) begin
      e_ren = bus.iREN; e_addr = bus.iaddr; e_iw = bus.iREN && !acc;
    end else if (owner == 2) begin
      e_wen = bus.dWEN; e_ren = bus.dREN && !bus.dWEN;
      e_addr = bus.daddr; e_store = bus.dstore; e_dw = dq && !acc;
    end
    check("ramREN", 32'(bus.ramREN), 32'(e_ren));
    check("ramWEN", 32'(bus.ramWEN), 32'(e_wen));
    check("ramaddr", bus.ramaddr, e_addr);
    check("ramstore", bus.ramstore, e_store);
    check("iwait", 32'(bus.iwait), 32'(e_iw));
    check("dwait", 32'(bus.dwait), 32'(e_dw));
    check("iload", bus.iload, bus.ramload);
    check("dload", bus.dload, bus.ramload);
`ifdef ARB_PERF_EN
    check("perf_igrants", perf_igrants, 32'(n_ig));
    check("perf_dgrants", perf_dgrants, 32'(n_dg));
    check("perf_stalls", perf_stalls, 32'(n_st));
`endif
  endtask

  task automatic update_model();
    logic dq, acc;
    dq = bus.dREN | bus.dWEN;
    acc = (bus.ramstate == RS_ACC);
    last_done_i = 0; last_done_d = 0;
    if (!nRST) begin
      reset_model();
    end else if (owner == 0) begin
      if (dq && !(bus.iREN && dstreak >= SM)) owner = 2;
      else if (bus.iREN) owner = 1;
      if (!bus.iREN) dstreak = 0;
    end else if (owner == 1) begin
      if (!acc) n_st++;
      if (bus.iREN && acc) begin n_ig++; dstreak = 0; last_done_i = 1; end
      if (!bus.iREN || acc) owner = 0;
    end else begin
      if (!acc) n_st++;
      if (dq && acc) begin
        n_dg++; last_done_d = 1;
        if (bus.iREN && dstreak < SM) dstreak++;
      end
      if (!dq || acc) owner = 0;
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    compare_outputs();
    if (watch) begin
      if (!seen_i && bus.ramREN && bus.dREN && !bus.dwait && bus.ramaddr == 32'h600) dcnt++;
      if (bus.ramREN && bus.ramaddr == 32'h500) seen_i = 1;
    end
    @(posedge CLK);
    update_model();
    #1;
  endtask

  task automatic xfer(input bit is_d, input logic [31:0] addr);
    if (is_d) begin bus.dREN = 1; bus.daddr = addr; end
    else begin bus.iREN = 1; bus.iaddr = addr; end
    bus.ramstate = RS_BUSY;
    tick(); tick();
    bus.ramstate = RS_ACC;
    tick();
    bus.iREN = 0; bus.dREN = 0;
  endtask

  task automatic gen();
    int k, r;
    if (!(bus.iREN && !last_done_i)) begin
      bus.iREN = ($urandom_range(0, 2) != 0);
      bus.iaddr = $urandom;
    end else if ($urandom_range(0, 19) == 0) begin
      bus.iREN = 0;
    end
    if (!((bus.dREN || bus.dWEN) && !last_done_d)) begin
      k = $urandom_range(0, 5);
      bus.dREN = (k == 1 || k == 3);
      bus.dWEN = (k == 2 || k == 3);
      bus.daddr = $urandom;
      bus.dstore = $urandom;
    end else if ($urandom_range(0, 19) == 0) begin
      bus.dREN = 0; bus.dWEN = 0;
    end
    r = $urandom_range(0, 9);
    bus.ramstate = (r < 5) ? RS_ACC : (r < 7) ? RS_BUSY : (r < 8) ? RS_FREE : RS_ERR;
    bus.ramload = $urandom;
  endtask

  initial begin
    nRST = 0;
    watch = 0; seen_i = 0; dcnt = 0;
    reset_model();
    bus.iREN = 1; bus.iaddr = 32'h40;
    bus.dREN = 0; bus.dWEN = 0; bus.daddr = 0; bus.dstore = 0;
    bus.ramstate = RS_ACC; bus.ramload = 32'hDEADBEEF;
    #1;
    check("rst_iwait", 32'(bus.iwait), 32'd1);
    check("rst_ramREN", 32'(bus.ramREN), 32'd0);
    tick(); tick();
    nRST = 1;
    tick();
    check("t1_ramaddr", bus.ramaddr, 32'h40);
    check("t1_iload", bus.iload, 32'hDEADBEEF);
    check("t1_iwait", 32'(bus.iwait), 32'd0);
    tick();
    bus.iREN = 0;
    tick();

    // Both requesters together: data first, fetch after one IDLE bubble.
    bus.iREN = 1; bus.iaddr = 32'h80; bus.dREN = 1; bus.daddr = 32'h100;
    tick();
    check("t2_daddr", bus.ramaddr, 32'h100);
    check("t2_iwait", 32'(bus.iwait), 32'd1);
    tick();
    bus.dREN = 0;
    tick();
    check("t2_iaddr", bus.ramaddr, 32'h80);
    tick();
    bus.iREN = 0;

    bus.dREN = 1; bus.dWEN = 1; bus.daddr = 32'h200; bus.dstore = 32'h12345678;
    tick();
    check("t3_ramWEN", 32'(bus.ramWEN), 32'd1);
    check("t3_ramREN", 32'(bus.ramREN), 32'd0);
    check("t3_ramstore", bus.ramstore, 32'h12345678);
    tick();
    bus.dREN = 0; bus.dWEN = 0;
    tick();

    bus.iREN = 1; bus.iaddr = 32'h500; bus.dREN = 1; bus.daddr = 32'h600;
    watch = 1;
    for (int i = 0; i < 14; i++) tick();
    watch = 0;
    check("starve_dcnt", 32'(dcnt), 32'(SM));
    check("starve_seen_i", 32'(seen_i), 32'd1);
    bus.iREN = 0; bus.dREN = 0;
    tick();

    // Abort: data request withdrawn while the RAM is still busy.
    bus.dREN = 1; bus.daddr = 32'h300; bus.ramstate = RS_BUSY;
    tick(); tick();
    bus.dREN = 0;
    tick();
    tick();

    bus.iREN = 1; bus.iaddr = 32'h44;
    tick(); tick();
    #2;
    nRST = 0;
    #1;
    check("arst_ramREN", 32'(bus.ramREN), 32'd0);
    check("arst_iwait", 32'(bus.iwait), 32'd1);
    reset_model();
    tick();
    nRST = 1; bus.iREN = 0;
    tick();

    xfer(0, 32'h10); xfer(1, 32'h20); xfer(0, 32'h30); xfer(1, 32'h40); xfer(0, 32'h50);
    tick();
`ifdef ARB_PERF_EN
    check("perf3_ig", perf_igrants, 32'd3);
    check("perf3_dg", perf_dgrants, 32'd2);
    check("perf3_st", perf_stalls, 32'd5);
`endif

    for (int i = 0; i < 4000; i++) begin
      gen();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
